// File: rtl/baud_pkg.sv
// baud_pkg: clock rate, standard 16x-oversample divisors and the default oversample ratio
// shared by the baud tick generator and its users.
package baud_pkg;
    localparam int BAUD_CLK_HZ        = 50_000_000;
    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int DIV_9600           = 325;
    localparam int DIV_38400          = 80;
    localparam int DIV_115200         = 26;
endpackage

// File: rtl/baud_prescaler.sv
// baud_prescaler: loadable divisor counter emitting the raw terminal-count strobe.
// Define BAUD_FRAC_EN to add the frac_val port and the fractional period accumulator.
module baud_prescaler #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 80,
    parameter int FRAC_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac_val,
`endif
    output logic             tc
);
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             w_hit;
    logic             w_hold;

    assign w_hit = r_cnt == r_div;
    assign tc    = en && w_hit && !w_hold && !div_load && !clr;

    // A held hit (fractional carry) keeps cnt at div_act for one extra clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_div <= DIV_W'(DEFAULT_DIV);
        end else if (div_load) begin
            r_div <= div_val;
            r_cnt <= '0;
        end else if (clr || tc) begin
            r_cnt <= '0;
        end else if (en && !w_hit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W-1:0] r_frac;
    logic              r_ext;

    assign w_hold = r_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_frac <= '0;
            r_ext  <= 1'b0;
        end else if (div_load) begin
            r_frac <= frac_val;
            r_acc  <= '0;
            r_ext  <= 1'b0;
        end else if (clr) begin
            r_ext <= 1'b0;
        end else if (en && w_hit) begin
            {r_ext, r_acc} <= r_ext ? {1'b0, r_acc} : {1'b0, r_acc} + {1'b0, r_frac};
        end
    end
`else
    // Without the accumulator a period is never stretched.
    assign w_hold = FRAC_W < 0;
`endif
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable oversample / mid-bit / bit tick generator for the UART paths.
// Define BAUD_FRAC_EN to enable the fractional divisor (frac_val port).
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int DEFAULT_DIV = 80,
    parameter int FRAC_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac_val,
`endif
    input  logic             resync,
    output logic             os_tick,
    output logic             mid_tick,
    output logic             bit_tick
);
    localparam int                OSC_W    = $clog2(OVERSAMPLE);
    localparam logic [OSC_W-1:0] MID_CNT  = OSC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OSC_W-1:0] LAST_CNT = OSC_W'(OVERSAMPLE - 1);

    logic             w_tc;
    logic [OSC_W-1:0] r_os_cnt;
    logic             r_os_tick;
    logic             r_mid_tick;
    logic             r_bit_tick;

    baud_prescaler #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .FRAC_W      (FRAC_W)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .clr      (resync),
        .div_load (div_load),
        .div_val  (div_val),
`ifdef BAUD_FRAC_EN
        .frac_val (frac_val),
`endif
        .tc       (w_tc)
    );

    // w_tc is already suppressed by div_load/resync, so strobes never produce a tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_os_cnt   <= '0;
            r_os_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
        end else begin
            r_os_tick  <= w_tc;
            r_mid_tick <= w_tc && r_os_cnt == MID_CNT;
            r_bit_tick <= w_tc && r_os_cnt == LAST_CNT;
            if (div_load || resync)
                r_os_cnt <= '0;
            else if (w_tc)
                r_os_cnt <= r_os_cnt == LAST_CNT ? '0 : r_os_cnt + 1'b1;
        end
    end

    assign os_tick  = r_os_tick;
    assign mid_tick = r_mid_tick;
    assign bit_tick = r_bit_tick;
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: cycle vector table plus directed period sequences for baud_tick_gen.
module tb_baud_tick_gen;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        div_load = 1'b0;
    logic        resync = 1'b0;
    logic [15:0] div_val = '0;
`ifdef BAUD_FRAC_EN
    logic [7:0]  frac_val = '0;
`endif
    logic        os_tick;
    logic        mid_tick;
    logic        bit_tick;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic        rs;
        logic        os;
        logic        mid;
        logic        bt;
    } vec_t;

    vec_t tbl[$];

    baud_tick_gen dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
`ifdef BAUD_FRAC_EN
        .frac_val (frac_val),
`endif
        .resync   (resync),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .bit_tick (bit_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic ld, input logic [15:0] v, input logic rs,
                       input logic os, input logic mid, input logic bt);
        tbl.push_back('{e, ld, v, rs, os, mid, bt});
    endtask

    // n = number of falling-edge samples until the chosen tick is seen high, -1 on timeout
    task automatic wait_for(input int which, input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if ((which == 0 && os_tick) || (which == 1 && mid_tick) || (which == 2 && bit_tick)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [7:0] f);
        div_val  = v;
`ifdef BAUD_FRAC_EN
        frac_val = f;
`else
        if (f != 8'd0) $display("note: fractional value ignored in this build");
`endif
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    initial begin
        int n;
        int c81;
        int c82;
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 0);
        add(1, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) add(1, 0, 0, 0, 1, k == 7, k == 15);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_os", os_tick, 0);
        chk("rst_mid", mid_tick, 0);
        chk("rst_bit", bit_tick, 0);

        en = 1'b1;
        reset_n = 1'b1;
        wait_for(0, 200, n);  chk("first_os", n, 81);
        wait_for(0, 200, n);  chk("os_period", n, 81);
        wait_for(2, 2000, n); chk("first_bit", n, 1134);
        wait_for(1, 2000, n); chk("mid_after_bit", n, 648);
        wait_for(2, 2000, n); chk("bit_after_mid", n, 648);
        wait_for(0, 200, n);  chk("os_after_bit", n, 81);

        foreach (tbl[i]) begin
            en = tbl[i].en;
            div_load = tbl[i].ld;
            div_val = tbl[i].val;
            resync = tbl[i].rs;
            @(negedge clk);
            chk($sformatf("vec%0d_os", i), os_tick, tbl[i].os);
            chk($sformatf("vec%0d_mid", i), mid_tick, tbl[i].mid);
            chk($sformatf("vec%0d_bit", i), bit_tick, tbl[i].bt);
        end
        div_load = 1'b0;
        resync = 1'b0;

        en = 1'b1;
        load(16'd80, 8'd0);
        repeat (30) @(negedge clk);
        en = 1'b0;
        c81 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (os_tick || mid_tick || bit_tick) c81++;
        end
        chk("stall_quiet", c81, 0);
        en = 1'b1;
        wait_for(0, 200, n); chk("stall_remainder", n, 51);

        repeat (20) @(negedge clk);
        load(16'd3, 8'd0);
        chk("load_no_tick", os_tick, 0);
        wait_for(0, 100, n); chk("load_os", n, 4);
        wait_for(1, 100, n); chk("load_mid", n, 28);
        wait_for(2, 100, n); chk("load_bit", n, 32);

        repeat (5) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        wait_for(1, 100, n); chk("resync_mid", n, 32);
        repeat (3) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        chk("resync_tc", os_tick, 0);
        wait_for(0, 100, n); chk("resync_tc_next", n, 4);

`ifdef BAUD_FRAC_EN
        load(16'd80, 8'd97);
        wait_for(0, 200, n); chk("frac_first", n, 81);
        c81 = 0;
        c82 = 0;
        for (int i = 0; i < 256; i++) begin
            wait_for(0, 200, n);
            if (n == 81) c81++;
            else if (n == 82) c82++;
        end
        chk("frac_82", c82, 97);
        chk("frac_81", c81, 159);
`endif

        wait_for(0, 200, n); chk("pre_rst_os", n > 0, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_os", os_tick, 0);
        chk("async_rst_mid", mid_tick, 0);
        chk("async_rst_bit", bit_tick, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_for(0, 200, n); chk("post_rst_os", n, 81);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised, runtime-programmable baud tick generator for the UART TX/RX paths. It replaces the fixed-divider 38400-baud pulse generator with a loadable divisor and an oversampling tick. It also provides a bit tick and a mid-bit sample tick, plus a resync input so the RX path can align sampling to a detected start-bit edge. It sits between the system clock domain and the `uart_tx` / `uart_rx` bit-level state machines.

## Interface
Parameters:
- `DIV_W`, 16: width of the divisor and prescaler counter.
- `OVERSAMPLE`, 16: `os_tick` pulses per bit. Must be even and ≥ 4.
- `DEFAULT_DIV`, 80: divisor loaded at reset. 50 MHz / (81 × 16) ≈ 38580 baud.
- `FRAC_W`, 8: fractional accumulator width. Used only with `BAUD_FRAC_EN`.

Ports:
- `clk`  in  1: system clock, 50 MHz nominal.
- `reset_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: count enable. When low, counters hold and all ticks are 0.
- `div_val`  in  DIV_W: divisor. `os_tick` period is `div_val`+1 clocks.
- `div_load`  in  1: single-cycle strobe that latches `div_val`.
- `frac_val`  in  FRAC_W: fractional divisor in 1/2^FRAC_W clock units. Latched with `div_load`. Present only with `BAUD_FRAC_EN`.
- `resync`  in  1: single-cycle strobe that restarts the bit phase.
- `os_tick`  out  1: oversample tick, one-cycle pulse.
- `mid_tick`  out  1: one-cycle pulse at the bit centre.
- `bit_tick`  out  1: one-cycle pulse at the end of each bit period.

## Operation
Internal state:
- `div_act`: active divisor.
- `cnt` [DIV_W]: prescaler counter.
- `os_cnt` [$clog2(OVERSAMPLE)]: oversample counter.

Prescaler:
- When `en`=1, `cnt` increments each clock.
- When `cnt == div_act`: `cnt` ← 0 and `os_tick` is asserted on the next cycle.
- `div_act == 0`: `os_tick` is asserted every enabled cycle.

Oversample counter:
- On each `os_tick` event, `os_cnt` increments and wraps from `OVERSAMPLE`-1 to 0.
- `mid_tick` fires with the `os_tick` event on which `os_cnt == OVERSAMPLE/2-1`.
- `bit_tick` fires with the `os_tick` event on which `os_cnt == OVERSAMPLE-1`.

`div_load`:
- `div_act` ← `div_val`.
- `cnt` ← 0 and `os_cnt` ← 0.
- The fractional accumulator is cleared.
- No tick is issued in that cycle.
- Takes effect regardless of `en`.

`resync`:
- `cnt` ← 0 and `os_cnt` ← 0.
- `div_act` is unchanged.
- After a resync, the first `mid_tick` is (OVERSAMPLE/2)·(div_act+1) clocks later. This makes it the RX start-bit centre when `resync` is pulsed on the falling edge.

Simultaneous strobes:
- `div_load` and `resync` in the same cycle: both apply, which equals `div_load` alone.
- `resync` on the same cycle as a terminal count: the resync wins and no tick is issued.

`en` low:
- `cnt`, `os_cnt` and the accumulator hold.
- Outputs are 0.
- Counting resumes from the held values when `en` returns high.

## Timing
- All outputs are registered: one clock of latency from the terminal-count condition to the pulse.
- Reset (asynchronous, `reset_n`=0) sets:
  - `cnt`=0, `os_cnt`=0, accumulator=0.
  - `div_act`=`DEFAULT_DIV`, frac=0.
  - `os_tick`=`mid_tick`=`bit_tick`=0.
- First `os_tick` after reset release with `en`=1: `DEFAULT_DIV`+1 clocks after the first enabled edge.
- Reset deasserted mid-bit: the phase restarts from 0. No partial pulse is produced.
- `bit_tick` and `mid_tick` always coincide with an `os_tick`. They never coincide with each other.

## Configuration
- `BAUD_FRAC_EN` defined:
  - `frac_val` port and a FRAC_W-bit accumulator are present.
  - On each terminal count, `acc` ← `acc` + `frac_act`.
  - A carry out extends the next prescaler period by one clock, giving an average period of `div_act` + 1 + `frac_act`/2^FRAC_W.
- `BAUD_FRAC_EN` undefined:
  - No `frac_val` port and no accumulator.
  - The period is exactly `div_act`+1.

## Structure
Package `baud_pkg` holds:
- `BAUD_CLK_HZ` = 50_000_000.
- Standard divisor constants: `DIV_9600`=325, `DIV_38400`=80, `DIV_115200`=26 (16× oversample).
- The `OVERSAMPLE` default.

Sub-module `baud_prescaler` contains the `cnt`/`div_act`/fractional accumulator and emits the raw terminal-count strobe. The top level adds `os_cnt`, tick decode, `resync` and the output registers.

## Test plan
- Reset release, `en`=1, `OVERSAMPLE`=16, `DEFAULT_DIV`=80 → `os_tick` every 81 clocks, `bit_tick` every 1296 clocks, `mid_tick` 648 clocks after `bit_tick`.
- `div_load` with `div_val`=3 mid-count → no tick that cycle. `os_tick` at +4, +8, …; `mid_tick` at +32; `bit_tick` at +64.
- `div_val`=0 → `os_tick` high every enabled cycle; `bit_tick` every 16 cycles.
- `resync` pulse at an arbitrary phase with divisor 3 → next `mid_tick` exactly 32 clocks later. `resync` coincident with a terminal count → no tick.
- `en` low for 100 cycles mid-period → all ticks 0. After re-enable, the remaining period equals the pre-stall remainder.
- Under `BAUD_FRAC_EN`, `div_val`=80, `frac_val`=97 → over 256 `os_tick`s, exactly 97 periods of 82 clocks and 159 periods of 81 clocks.
- `reset_n` asserted asynchronously while `os_tick` is high → outputs drop immediately, and the reset state matches the Timing section.
